// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle ALU path and a FIFO of load
// results onto the register file's one write port. ALU always wins; queued
// loads drain in cycles the ALU leaves idle.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1,
  localparam int unsigned NR   = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [NR-1:0] pending,
  output logic [CW-1:0] fifo_count,
  output logic          ovf_err,
  output logic          waw_err
);

  logic [AW-1:0] dest_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          ovf_q, waw_q;
  logic          push, pop;

  // Ready depends on occupancy only; a same-cycle pop does not free a slot early.
  assign mem_ready  = (count_q != CW'(DEPTH));
  assign push       = mem_valid && mem_ready;
  assign pop        = !alu_valid && (count_q != '0);
  assign fifo_count = count_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign ovf_err    = ovf_q;
  assign waw_err    = waw_q;

  // Pending vector: one-hot dest of every occupied slot, ORed together.
  always_comb begin
    logic [PW-1:0] off;
    off     = '0;
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (CW'(off) < count_q) begin
        pending[dest_q[i]] = 1'b1;
      end
    end
  end

  // Load storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail_q] <= mem_dest;
      data_q[tail_q] <= mem_data;
    end
  end

  // Pointers, count, registered write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      waw_q     <= 1'b0;
    end else begin
      wr_en_q <= alu_valid || pop;
      if (alu_valid) begin
        wr_addr_q <= alu_dest;
        wr_data_q <= alu_data;
      end else if (pop) begin
        wr_addr_q <= dest_q[head_q];
        wr_data_q <= data_q[head_q];
      end
      head_q <= head_q + PW'(pop);
      tail_q <= tail_q + PW'(push);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem_valid && !mem_ready) ovf_q <= 1'b1;
      if (alu_valid && pending[alu_dest]) waw_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a queue-based model predicts every register-file write;
// a negedge monitor pops predictions as writes appear and cross-checks status.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready, wr_en, ovf_err, waw_err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pending;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .mem_ready(mem_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .fifo_count(fifo_count), .ovf_err(ovf_err), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  // Model state: queued loads and expected writes, each {dest, data}.
  logic [19:0] mq[$];
  logic [19:0] exp_q[$];
  logic        m_ovf = 1'b0, m_waw = 1'b0;
  bit          mon_on = 1'b0;
  int          n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] p = '0;
    foreach (mq[i]) p[mq[i][19:16]] = 1'b1;
    return p;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic step(input logic r, input logic av, input logic [3:0] ad,
                      input logic [15:0] adat, input logic mv, input logic [3:0] md,
                      input logic [15:0] mdat);
    int sz;
    logic hit;
    rst = r; alu_valid = av; alu_dest = ad; alu_data = adat;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    @(posedge clk);
    if (r) begin
      mq.delete(); exp_q.delete(); m_ovf = 1'b0; m_waw = 1'b0;
    end else begin
      sz  = mq.size();
      hit = model_pending()[ad];
      if (av) begin
        exp_q.push_back({ad, adat});
        if (hit) m_waw = 1'b1;
      end else if (sz > 0) begin
        exp_q.push_back(mq.pop_front());
      end
      if (mv) begin
        if (sz < DEPTH) mq.push_back({md, mdat});
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask

  // Monitor: every presented write must match the oldest prediction.
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {12'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("write", {12'd0, wr_addr, wr_data}, {12'd0, e});
        end
      end
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("pending", 32'(pending), 32'(model_pending()));
      chk("mem_ready", 32'(mem_ready), 32'(mq.size() != DEPTH));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("waw_err", 32'(waw_err), 32'(m_waw));
    end
  end

  initial begin
    // Reset with a load offered: nothing may be queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 16'h5555);
    mon_on = 1'b1;
    idle(1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);

    // ALU only.
    step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'd0);
    chk("alu_wr", {15'd0, wr_en, 12'd0, wr_addr}, {15'd0, 1'b1, 12'd0, 4'd3});
    idle(1);
    chk("alu_wr_off", 32'(wr_en), 32'd0);

    // Single load: two-cycle latency, pending while queued.
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h1234);
    chk("load_pending", 32'(pending), 32'h0020);
    chk("load_no_bypass", 32'(wr_en), 32'd0);
    idle(1);
    chk("load_wr", {12'd0, wr_addr, wr_data}, {12'd0, 4'd5, 16'h1234});
    chk("load_drained", 32'(pending), 32'd0);

    // Fill under ALU priority, overflow, then ordered drain.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 4'd1, 16'(i), 1'b1, 4'(i + 2), 16'(16'hA000 + i));
    chk("fill_ready", 32'(mem_ready), 32'd0);
    step(1'b0, 1'b1, 4'd1, 16'hFF, 1'b1, 4'd6, 16'hDEAD);
    chk("fill_ovf", 32'(ovf_err), 32'd1);
    chk("fill_count", 32'(fifo_count), 32'd4);
    idle(6);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

    // Wrap-around with same-cycle push and pop.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'(i % 3 == 0), 4'hE, 16'($urandom), 1'b1, 4'(i), 16'($urandom));
    idle(6);

    // WAW: ALU hits a register with a queued load.
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7777);
    step(1'b0, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 16'd0);
    chk("waw_set", 32'(waw_err), 32'd1);
    idle(3);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    chk("waw_cleared", 32'(waw_err), 32'd0);

    // Reset mid-drain discards queued loads.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'd0, 16'd1, 1'b1, 4'(i + 8), 16'(i));
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    chk("middrain_count", 32'(fifo_count), 32'd0);
    idle(4);

    // Randomized traffic with varying ALU pressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      int unsigned thr = (i / 150) * 30;
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) < thr),
           4'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           4'($urandom), 16'($urandom));
    end

    // Bounded drain, then every predicted write must have been seen.
    for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1);
    idle(2);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
